// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: bus widths, response codes, the write-beat
// payload and the byte-strobe merge helper.
package axil_pkg;

    localparam int unsigned AXIL_DATA_WIDTH = 32;
    localparam int unsigned AXIL_STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One accepted W beat: data plus its byte enables.
    typedef struct packed {
        logic [AXIL_DATA_WIDTH-1:0] data;
        logic [AXIL_STRB_WIDTH-1:0] strb;
    } axil_wbeat_t;

    // Replace the bytes of old_val whose strobe bit is set.
    function automatic logic [AXIL_DATA_WIDTH-1:0] apply_strb(
        input logic [AXIL_DATA_WIDTH-1:0] old_val,
        input logic [AXIL_DATA_WIDTH-1:0] new_val,
        input logic [AXIL_STRB_WIDTH-1:0] strb
    );
        logic [AXIL_DATA_WIDTH-1:0] merged;
        merged = old_val;
        for (int unsigned b = 0; b < AXIL_STRB_WIDTH; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_register_responder.sv
// AXI-Lite subordinate exposing NUM_REGS 32-bit read/write registers.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   s_aw*, s_w*, s_b*   : write address / data / response channels
//   s_ar*, s_r*         : read address / data channels
//   regs_out            : flat view of register contents, reg k at [32k+31:32k]
// AW and W each land in a one-entry holding register; the write fires once
// both are full and the B slot is free. Reads answer one cycle after AR.
module axil_register_responder
    import axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                                clk,
    input  logic                                reset,

    input  logic [ADDR_WIDTH-1:0]               s_awaddr,
    input  logic                                s_awvalid,
    output logic                                s_awready,

    input  logic [AXIL_DATA_WIDTH-1:0]          s_wdata,
    input  logic [AXIL_STRB_WIDTH-1:0]          s_wstrb,
    input  logic                                s_wvalid,
    output logic                                s_wready,

    output logic [1:0]                          s_bresp,
    output logic                                s_bvalid,
    input  logic                                s_bready,

    input  logic [ADDR_WIDTH-1:0]               s_araddr,
    input  logic                                s_arvalid,
    output logic                                s_arready,

    output logic [AXIL_DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                          s_rresp,
    output logic                                s_rvalid,
    input  logic                                s_rready,

    output logic [AXIL_DATA_WIDTH*NUM_REGS-1:0] regs_out
);

    localparam int unsigned IDX_WIDTH = ADDR_WIDTH - 2;

    logic                       aw_full;
    logic [IDX_WIDTH-1:0]       aw_idx;
    logic                       w_full;
    axil_wbeat_t                w_beat;
    logic [AXIL_DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                       write_fire_c;
    logic                       aw_hs_c;
    logic                       w_hs_c;
    logic                       ar_hs_c;
    logic                       aw_in_range_c;
    logic                       ar_in_range_c;
    logic [IDX_WIDTH-1:0]       ar_idx_c;
    logic [AXIL_DATA_WIDTH-1:0] rd_value_c;

    // Byte-offset bits carry no information for word registers.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

    // Handshakes; readies see the downstream ready so a drained slot refills in the same cycle.
    assign write_fire_c = aw_full && w_full && (!s_bvalid || s_bready);
    assign s_awready    = !reset && (!aw_full || write_fire_c);
    assign s_wready     = !reset && (!w_full || write_fire_c);
    assign s_arready    = !reset && (!s_rvalid || s_rready);
    assign aw_hs_c      = s_awvalid && s_awready;
    assign w_hs_c       = s_wvalid && s_wready;
    assign ar_hs_c      = s_arvalid && s_arready;

    assign ar_idx_c      = s_araddr[ADDR_WIDTH-1:2];
    assign aw_in_range_c = 32'(aw_idx) < NUM_REGS;
    assign ar_in_range_c = 32'(ar_idx_c) < NUM_REGS;

    // Read mux; an out-of-range index matches nothing and yields zero.
    always_comb begin
        rd_value_c = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (ar_idx_c == IDX_WIDTH'(k)) begin
                rd_value_c = regs[k];
            end
        end
    end

    // Register file; a same-edge read samples the pre-write value via rd_value_c.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (write_fire_c && aw_in_range_c) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (aw_idx == IDX_WIDTH'(k)) begin
                    regs[k] <= apply_strb(regs[k], w_beat.data, w_beat.strb);
                end
            end
        end
    end

    // Holding registers and write response.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full  <= 1'b0;
            aw_idx   <= '0;
            w_full   <= 1'b0;
            w_beat   <= '0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else begin
            if (aw_hs_c) begin
                aw_full <= 1'b1;
                aw_idx  <= s_awaddr[ADDR_WIDTH-1:2];
            end else if (write_fire_c) begin
                aw_full <= 1'b0;
            end

            if (w_hs_c) begin
                w_full      <= 1'b1;
                w_beat.data <= s_wdata;
                w_beat.strb <= s_wstrb;
            end else if (write_fire_c) begin
                w_full <= 1'b0;
            end

            if (write_fire_c) begin
                s_bvalid <= 1'b1;
                s_bresp  <= aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
            end else if (s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // Read response.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs_c) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_value_c;
            s_rresp  <= ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
        assign regs_out[AXIL_DATA_WIDTH*k +: AXIL_DATA_WIDTH] = regs[k];
    end

endmodule

// File: tb/tb_axil_register_responder.sv
// Self-checking bench for axil_register_responder: directed table, stall,
// back-to-back read, reset and randomized transaction-level checks.
module tb_axil_register_responder;
    import axil_pkg::*;

    localparam int unsigned AW = 6;
    localparam int unsigned NR = 4;
    localparam int NW  = 48;
    localparam int NRD = 48;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] s_awaddr;
    logic          s_awvalid;
    logic          s_awready;
    logic [31:0]   s_wdata;
    logic [3:0]    s_wstrb;
    logic          s_wvalid;
    logic          s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid;
    logic          s_bready;
    logic [AW-1:0] s_araddr;
    logic          s_arvalid;
    logic          s_arready;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rvalid;
    logic          s_rready;
    logic [32*NR-1:0] regs_out;

    always #5 clk = ~clk;

    axil_register_responder #(.ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_out(regs_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_view(input int k);
        return regs_out[32*k +: 32];
    endfunction

    // Expected register value after merging bytes whose strobe is set.
    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    task automatic idle();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
    endtask

    // W leads AW by 'lead' cycles; B must appear exactly two cycles after AW.
    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead,
                            input logic [1:0] exp_resp, input string tag);
        @(negedge clk);
        s_bready = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1; s_awaddr = addr;
        if (lead == 0) s_awvalid = 1'b1;
        for (int i = 1; i <= lead; i++) begin
            @(negedge clk);
            s_wvalid = 1'b0;
            chk({tag, "_b_wait"}, 32'(s_bvalid), 32'd0);
            if (i == lead) s_awvalid = 1'b1;
        end
        @(negedge clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        chk({tag, "_b_early"}, 32'(s_bvalid), 32'd0);
        @(negedge clk);
        chk({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
        @(negedge clk);
        s_rready = 1'b1; s_araddr = addr; s_arvalid = 1'b1;
        #1 chk({tag, "_arready"}, 32'(s_arready), 32'd1);
        @(negedge clk);
        s_arvalid = 1'b0;
        chk({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
        chk({tag, "_rdata"}, s_rdata, exp_data);
        chk({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        int            lead;
        logic [1:0]    bresp;
        logic [31:0]   rdata;
        logic [1:0]    rresp;
    } vec_t;

    vec_t vecs[8];

    logic [AW-1:0] st_addr[3];
    logic [31:0]   st_data[3];
    logic [3:0]    st_strb[3];
    logic [1:0]    st_resp[3];

    logic [AW-1:0] wa[NW];
    logic [31:0]   wd[NW];
    logic [3:0]    ws[NW];
    logic [AW-1:0] ra[NRD];
    logic [31:0]   mem[NR];
    logic [1:0]    exp_b[$];
    logic [31:0]   exp_rd[$];
    logic [1:0]    exp_rr[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int an, wn, bn, ai, wi, pairs, bgot, ri, rgot, idx;
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs, stall_prev;
        logic [1:0] prev_bresp, prev_rresp;
        logic [31:0] prev_rdata;
        logic [31:0] vals[4];

        vecs[0] = '{6'h04, 32'hDEADBEEF, 4'hF, 0, RESP_OKAY,   32'hDEADBEEF, RESP_OKAY};
        vecs[1] = '{6'h00, 32'h11223344, 4'hF, 2, RESP_OKAY,   32'h11223344, RESP_OKAY};
        vecs[2] = '{6'h00, 32'hAABBCCDD, 4'h5, 0, RESP_OKAY,   32'h11BB33DD, RESP_OKAY};
        vecs[3] = '{6'h10, 32'h12345678, 4'hF, 0, RESP_SLVERR, 32'h00000000, RESP_SLVERR};
        vecs[4] = '{6'h0E, 32'hCAFEF00D, 4'hC, 1, RESP_OKAY,   32'hCAFE0000, RESP_OKAY};
        vecs[5] = '{6'h09, 32'h55555555, 4'h0, 0, RESP_OKAY,   32'h00000000, RESP_OKAY};
        vecs[6] = '{6'h3F, 32'hFFFFFFFF, 4'hF, 0, RESP_SLVERR, 32'h00000000, RESP_SLVERR};
        vecs[7] = '{6'h07, 32'h00000077, 4'h1, 0, RESP_OKAY,   32'hDEADBE77, RESP_OKAY};

        reset = 1'b1;
        s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
        idle();
        s_bready = 1'b1; s_rready = 1'b1;

        // Reset state
        @(negedge clk);
        #1 chk("rst_awready", 32'(s_awready), 32'd0);
        chk("rst_wready", 32'(s_wready), 32'd0);
        chk("rst_arready", 32'(s_arready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        chk("rst_bresp", 32'(s_bresp), 32'(RESP_OKAY));
        chk("rst_rresp", 32'(s_rresp), 32'(RESP_OKAY));
        for (int k = 0; k < 4; k++) chk("rst_regs", reg_view(k), 32'd0);
        #1 chk("post_rst_awready", 32'(s_awready), 32'd1);

        // Directed table: write then read back
        for (int v = 0; v < 8; v++) begin
            do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].lead, vecs[v].bresp, "tbl_wr");
            do_read(vecs[v].addr, vecs[v].rdata, vecs[v].rresp, "tbl_rd");
        end
        @(negedge clk);
        chk("tbl_reg0", reg_view(0), 32'h11BB33DD);
        chk("tbl_reg1", reg_view(1), 32'hDEADBE77);
        chk("tbl_reg2", reg_view(2), 32'h00000000);
        chk("tbl_reg3", reg_view(3), 32'hCAFE0000);

        // B stalled for 5 cycles with three writes offered back to back
        st_addr[0] = 6'h08; st_data[0] = 32'h01010101; st_strb[0] = 4'hF; st_resp[0] = RESP_OKAY;
        st_addr[1] = 6'h20; st_data[1] = 32'hBAD0BAD0; st_strb[1] = 4'hF; st_resp[1] = RESP_SLVERR;
        st_addr[2] = 6'h0C; st_data[2] = 32'h03030303; st_strb[2] = 4'h3; st_resp[2] = RESP_OKAY;
        an = 0; wn = 0; bn = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            s_bready  = (cyc >= 5);
            s_awvalid = (an < 3);
            s_wvalid  = (wn < 3);
            s_awaddr  = st_addr[(an < 3) ? an : 2];
            s_wdata   = st_data[(wn < 3) ? wn : 2];
            s_wstrb   = st_strb[(wn < 3) ? wn : 2];
            #1;
            if (cyc >= 2 && cyc <= 4) begin
                chk("stall_awready", 32'(s_awready), 32'd0);
                chk("stall_wready", 32'(s_wready), 32'd0);
                chk("stall_bvalid", 32'(s_bvalid), 32'd1);
                chk("stall_bresp", 32'(s_bresp), 32'(RESP_OKAY));
            end
            if (s_bvalid && s_bready) begin
                chk("stall_b_order", 32'(s_bresp), 32'(st_resp[(bn < 3) ? bn : 2]));
                bn++;
            end
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(posedge clk); #1;
            if (aw_hs) an++;
            if (w_hs) wn++;
            if (cyc == 4) chk("stall_accepted", 32'(an), 32'd2);
        end
        idle();
        chk("stall_b_count", 32'(bn), 32'd3);
        chk("stall_reg2", reg_view(2), 32'h01010101);
        chk("stall_reg3", reg_view(3), 32'hCAFE0303);

        // Back-to-back reads with a same-edge write to reg 1
        for (int k = 0; k < 4; k++) begin
            vals[k] = 32'hC0DE0000 + 32'(k);
            do_write(6'(4*k), vals[k], 4'hF, 0, RESP_OKAY, "b2b_init");
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_rready = 1'b1; s_bready = 1'b1;
            if (i > 0 && i < 5) begin
                chk("b2b_rvalid", 32'(s_rvalid), 32'd1);
                chk("b2b_rdata", s_rdata, vals[i-1]);
            end
            if (i == 5) chk("b2b_rvalid_end", 32'(s_rvalid), 32'd0);
            s_arvalid = (i < 4);
            s_araddr  = 6'(4*i);
            s_awvalid = (i == 0); s_awaddr = 6'h04;
            s_wvalid  = (i == 0); s_wdata = 32'h5A5A5A5A; s_wstrb = 4'hF;
        end
        idle();
        do_read(6'h04, 32'h5A5A5A5A, RESP_OKAY, "b2b_new");

        // Randomized writes against a transaction-level model
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int k = 0; k < 4; k++) mem[k] = '0;
        for (int k = 0; k < NW; k++) begin
            wa[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
            wd[k] = $urandom;
            ws[k] = 4'($urandom);
        end
        ai = 0; wi = 0; pairs = 0; bgot = 0; stall_prev = 1'b0; prev_bresp = '0;
        for (int cyc = 0; cyc < 3000 && bgot < NW; cyc++) begin
            @(negedge clk);
            if (!s_awvalid && ai < NW && $urandom_range(0, 2) != 0) begin
                s_awvalid = 1'b1; s_awaddr = wa[ai];
            end
            if (!s_wvalid && wi < NW && $urandom_range(0, 2) != 0) begin
                s_wvalid = 1'b1; s_wdata = wd[wi]; s_wstrb = ws[wi];
            end
            s_bready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                chk("rw_b_hold_valid", 32'(s_bvalid), 32'd1);
                chk("rw_b_hold_resp", 32'(s_bresp), 32'(prev_bresp));
            end
            stall_prev = s_bvalid && !s_bready;
            prev_bresp = s_bresp;
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            b_hs  = s_bvalid && s_bready;
            if (b_hs) begin
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rw_b_unexpected: got bresp %0d with no write pending", s_bresp);
                end else begin
                    chk("rw_bresp", 32'(s_bresp), 32'(exp_b.pop_front()));
                end
                bgot++;
            end
            @(posedge clk); #1;
            if (aw_hs) begin ai++; s_awvalid = 1'b0; end
            if (w_hs) begin wi++; s_wvalid = 1'b0; end
            while (pairs < ai && pairs < wi) begin
                idx = int'(wa[pairs][AW-1:2]);
                if (idx < int'(NR)) begin
                    mem[idx] = merge(mem[idx], wd[pairs], ws[pairs]);
                    exp_b.push_back(RESP_OKAY);
                end else begin
                    exp_b.push_back(RESP_SLVERR);
                end
                pairs++;
            end
        end
        idle();
        chk("rw_b_count", 32'(bgot), 32'(NW));
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk("rw_regs", reg_view(k), mem[k]);

        // Randomized reads against the model
        for (int k = 0; k < NRD; k++)
            ra[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(16, 63)) : 6'($urandom_range(0, 15));
        ri = 0; rgot = 0; stall_prev = 1'b0; prev_rdata = '0; prev_rresp = '0;
        for (int cyc = 0; cyc < 3000 && rgot < NRD; cyc++) begin
            @(negedge clk);
            if (!s_arvalid && ri < NRD && $urandom_range(0, 2) != 0) begin
                s_arvalid = 1'b1; s_araddr = ra[ri];
            end
            s_rready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                chk("rd_hold_valid", 32'(s_rvalid), 32'd1);
                chk("rd_hold_data", s_rdata, prev_rdata);
                chk("rd_hold_resp", 32'(s_rresp), 32'(prev_rresp));
            end
            stall_prev = s_rvalid && !s_rready;
            prev_rdata = s_rdata;
            prev_rresp = s_rresp;
            ar_hs = s_arvalid && s_arready;
            r_hs  = s_rvalid && s_rready;
            if (r_hs) begin
                if (exp_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rd_unexpected: got rdata 0x%08h with no read pending", s_rdata);
                end else begin
                    chk("rd_rdata", s_rdata, exp_rd.pop_front());
                    chk("rd_rresp", 32'(s_rresp), 32'(exp_rr.pop_front()));
                end
                rgot++;
            end
            @(posedge clk); #1;
            if (ar_hs) begin
                idx = int'(ra[ri][AW-1:2]);
                if (idx < int'(NR)) begin
                    exp_rd.push_back(mem[idx]); exp_rr.push_back(RESP_OKAY);
                end else begin
                    exp_rd.push_back(32'd0); exp_rr.push_back(RESP_SLVERR);
                end
                ri++;
                s_arvalid = 1'b0;
            end
        end
        idle();
        chk("rd_count", 32'(rgot), 32'(NRD));

        // Reset with AW held, B pending and R pending
        @(negedge clk); s_bready = 1'b1; s_rready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0; s_rready = 1'b0;
        s_awaddr = 6'h08; s_awvalid = 1'b1;
        s_wdata = 32'h77777777; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 6'h00; s_arvalid = 1'b1;
        @(negedge clk);
        idle();
        @(negedge clk);
        s_awaddr = 6'h00; s_awvalid = 1'b1;
        @(negedge clk);
        s_awvalid = 1'b0;
        chk("mid_pre_bvalid", 32'(s_bvalid), 32'd1);
        chk("mid_pre_rvalid", 32'(s_rvalid), 32'd1);
        chk("mid_pre_reg2", reg_view(2), 32'h77777777);
        s_bready = 1'b1; s_rready = 1'b1;
        reset = 1'b1;
        #1 chk("mid_rst_awready", 32'(s_awready), 32'd0);
        chk("mid_rst_wready", 32'(s_wready), 32'd0);
        chk("mid_rst_arready", 32'(s_arready), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_bvalid", 32'(s_bvalid), 32'd0);
        chk("mid_rvalid", 32'(s_rvalid), 32'd0);
        chk("mid_rdata", s_rdata, 32'd0);
        chk("mid_bresp", 32'(s_bresp), 32'(RESP_OKAY));
        chk("mid_rresp", 32'(s_rresp), 32'(RESP_OKAY));
        for (int k = 0; k < 4; k++) chk("mid_regs", reg_view(k), 32'd0);
        // A lone W must not pair with the address dropped by reset.
        s_wdata = 32'h12121212; s_wstrb = 4'hF; s_wvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s_wvalid = 1'b0;
            chk("mid_no_stale_b", 32'(s_bvalid), 32'd0);
            chk("mid_no_stale_r", 32'(s_rvalid), 32'd0);
        end
        chk("mid_reg0_untouched", reg_view(0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
